// File: rtl/svm_job_scheduler.sv
// Round-robin job scheduler in front of a linear_svm core: grants one requester,
// issues its feature vector, waits for the result (or a timeout) and holds the response.
module svm_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_FEATURES   = 20,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int FW            = NUM_FEATURES * DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*FW-1:0]   req_features,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    svm_input_valid,
    output logic [FW-1:0]           svm_features_flat,
    input  logic                    svm_output_valid,
    input  logic [DATA_WIDTH-1:0]   svm_decision,
    input  logic                    svm_prediction,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [DATA_WIDTH-1:0]   rsp_decision,
    output logic                    rsp_prediction,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [15:0]             timeout_count
);

    localparam int          TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_next;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] win_idx;
    logic           win_found;
    logic [TW-1:0]  timer;
    logic           grant;
    logic           timer_expired;
    int unsigned    cand;

    // Search starts just after the previous owner and wraps around.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int unsigned i = 1; i <= NR; i++) begin
            cand = 32'(last_grant) + i;
            if (cand >= NR) cand = cand - NR;
            if (!win_found && req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    // rst_n gating keeps the combinational grant silent while reset is held.
    assign grant         = (state == IDLE) && enable && win_found && rst_n;
    assign req_ready     = grant ? (NUM_REQ'(1) << win_idx) : '0;
    assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next      = state;
        svm_input_valid = 1'b0;
        rsp_valid       = 1'b0;
        busy            = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant) state_next = ISSUE;
            end
            ISSUE: begin
                svm_input_valid = 1'b1;
                state_next      = WAIT;
            end
            WAIT: begin
                if (svm_output_valid || timer_expired) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            svm_features_flat <= '0;
            rsp_id            <= '0;
            last_grant        <= IDW'(NUM_REQ - 1);
            timer             <= '0;
            rsp_decision      <= '0;
            rsp_prediction    <= 1'b0;
            rsp_timeout       <= 1'b0;
            timeout_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        svm_features_flat <= req_features[win_idx*FW +: FW];
                        rsp_id            <= win_idx;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= timer + 1'b1;
                    // A result arriving on the expiry cycle takes precedence.
                    if (svm_output_valid) begin
                        rsp_decision   <= svm_decision;
                        rsp_prediction <= svm_prediction;
                        rsp_timeout    <= 1'b0;
                    end else if (timer_expired) begin
                        rsp_decision   <= '0;
                        rsp_prediction <= 1'b0;
                        rsp_timeout    <= 1'b1;
                        if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) last_grant <= rsp_id;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_svm_job_scheduler.sv
// Transaction-level bench for svm_job_scheduler: random jobs checked against a
// round-robin / latency / timeout reference model.
module tb_svm_job_scheduler;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int NF  = 20;
    localparam int TO  = 64;
    localparam int IDW = 2;
    localparam int FW  = NF * DW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [NR-1:0]     req_valid;
    logic [NR*FW-1:0]  req_features;
    logic [NR-1:0]     req_ready;
    logic              svm_input_valid;
    logic [FW-1:0]     svm_features_flat;
    logic              svm_output_valid;
    logic [DW-1:0]     svm_decision;
    logic              svm_prediction;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [DW-1:0]     rsp_decision;
    logic              rsp_prediction;
    logic              rsp_timeout;
    logic              busy;
    logic [15:0]       timeout_count;

    svm_job_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_FEATURES(NF), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid),
        .req_features(req_features), .req_ready(req_ready),
        .svm_input_valid(svm_input_valid), .svm_features_flat(svm_features_flat),
        .svm_output_valid(svm_output_valid), .svm_decision(svm_decision),
        .svm_prediction(svm_prediction), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_decision(rsp_decision), .rsp_prediction(rsp_prediction),
        .rsp_timeout(rsp_timeout), .busy(busy), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          last_m;
    logic [15:0] cnt_m;

    task automatic check(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input int last, input logic [NR-1:0] v);
        for (int i = 1; i <= NR; i++) begin
            if (v[(last + i) % NR]) return (last + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [FW-1:0] rand_feat();
        logic [FW-1:0] f;
        for (int w = 0; w < FW / 32; w++) f[w*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        enable = 1'b0;
        req_valid = '0;
        svm_output_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last_m = NR - 1;
        cnt_m  = '0;
    endtask

    task automatic idle_drop(input logic [NR-1:0] pat);
        enable = 1'b0;
        req_valid = pat;
        #1;
        check("ready_disabled", FW'(req_ready), '0);
        tick;
        check("busy_disabled", FW'(busy), '0);
    endtask

    // One job: grant, issue, wait lat WAIT cycles (lat > TO means silent core), respond.
    task automatic run_job(input logic [NR-1:0] pat, input int lat, input logic [DW-1:0] dec,
                           input logic pred, input int bp, input int rst_at,
                           output logic [NR-1:0] got_ready);
        logic [FW-1:0]    feats[NR];
        logic [NR*FW-1:0] flat;
        logic [NR-1:0]    exp_ready;
        logic [DW-1:0]    exp_dec;
        logic             exp_pred, exp_tmo;
        int               win;
        for (int r = 0; r < NR; r++) begin
            feats[r] = rand_feat();
            flat[r*FW +: FW] = feats[r];
        end
        req_features = flat;
        req_valid = pat;
        enable = 1'b1;
        rsp_ready = 1'b0;
        #1;
        win = rr_pick(last_m, pat);
        exp_ready = '0;
        exp_ready[win] = 1'b1;
        got_ready = req_ready;
        check("req_ready", FW'(req_ready), FW'(exp_ready));
        check("busy_idle", FW'(busy), '0);
        tick;
        // Inputs scrambled after the handshake must not disturb the job.
        req_valid = NR'($urandom);
        req_features = {NR{rand_feat()}};
        enable = 1'($urandom_range(0, 1));
        svm_output_valid = 1'($urandom_range(0, 1));
        svm_decision = DW'($urandom);
        svm_prediction = 1'($urandom);
        #1;
        check("svm_input_valid", FW'(svm_input_valid), FW'(1));
        check("features", svm_features_flat, feats[win]);
        check("ready_issue", FW'(req_ready), '0);
        check("busy_issue", FW'(busy), FW'(1));
        for (int k = 1; k <= TO; k++) begin
            tick;
            svm_output_valid = 1'b0;
            #1;
            check("in_valid_wait", FW'(svm_input_valid), '0);
            check("rsp_valid_wait", FW'(rsp_valid), '0);
            check("ready_wait", FW'(req_ready), '0);
            if (k == rst_at) begin
                req_valid = '1;
                enable = 1'b1;
                rst_n = 1'b0;
                #1;
                check("rst_busy", FW'(busy), '0);
                check("rst_rsp_valid", FW'(rsp_valid), '0);
                check("rst_ready", FW'(req_ready), '0);
                check("rst_features", svm_features_flat, '0);
                check("rst_id", FW'(rsp_id), '0);
                check("rst_tcount", FW'(timeout_count), '0);
                check("rst_in_valid", FW'(svm_input_valid), '0);
                tick;
                rst_n = 1'b1;
                enable = 1'b0;
                last_m = NR - 1;
                cnt_m = '0;
                for (int j = 0; j < 3; j++) begin
                    svm_output_valid = 1'b1;
                    #1;
                    check("late_result_rsp", FW'(rsp_valid), '0);
                    check("late_result_busy", FW'(busy), '0);
                    tick;
                end
                svm_output_valid = 1'b0;
                req_valid = '0;
                return;
            end
            if (k == lat) begin
                svm_output_valid = 1'b1;
                svm_decision = dec;
                svm_prediction = pred;
                break;
            end
        end
        tick;
        svm_output_valid = 1'($urandom_range(0, 1));
        svm_decision = DW'($urandom);
        if (lat <= TO) begin
            exp_dec = dec; exp_pred = pred; exp_tmo = 1'b0;
        end else begin
            exp_dec = '0; exp_pred = 1'b0; exp_tmo = 1'b1;
            if (cnt_m != 16'hFFFF) cnt_m++;
        end
        for (int b = 0; b <= bp; b++) begin
            rsp_ready = (b == bp);
            req_valid = NR'($urandom);
            enable = 1'b1;
            #1;
            check("rsp_valid", FW'(rsp_valid), FW'(1));
            check("rsp_id", FW'(rsp_id), FW'(win));
            check("rsp_decision", FW'(rsp_decision), FW'(exp_dec));
            check("rsp_prediction", FW'(rsp_prediction), FW'(exp_pred));
            check("rsp_timeout", FW'(rsp_timeout), FW'(exp_tmo));
            check("timeout_count", FW'(timeout_count), FW'(cnt_m));
            check("ready_resp", FW'(req_ready), '0);
            tick;
        end
        rsp_ready = 1'b0;
        req_valid = '0;
        svm_output_valid = 1'b0;
        #1;
        check("rsp_valid_done", FW'(rsp_valid), '0);
        check("busy_done", FW'(busy), '0);
        last_m = win;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] got;
        int            order[5];
        int            lat;
        order = '{0, 1, 2, 3, 0};
        req_features = '0;
        svm_decision = '0;
        svm_prediction = 1'b0;
        do_reset;
        #1;
        check("reset_busy", FW'(busy), '0);
        check("reset_rsp_valid", FW'(rsp_valid), '0);
        check("reset_tcount", FW'(timeout_count), '0);
        check("reset_in_valid", FW'(svm_input_valid), '0);
        check("reset_features", svm_features_flat, '0);

        run_job(4'b0100, 3, 16'h0180, 1'b1, 0, 0, got);

        do_reset;
        for (int j = 0; j < 5; j++) begin
            run_job(4'b1111, $urandom_range(1, 6), DW'($urandom), 1'($urandom), 0, 0, got);
            check("rr_order", FW'(got), FW'(NR'(1) << order[j]));
        end

        run_job(4'b1111, TO + 5, 16'h1234, 1'b1, 0, 0, got);
        run_job(4'b0011, TO, 16'h0abc, 1'b1, 0, 0, got);
        run_job(4'b1000, TO - 1, 16'h7f00, 1'b0, 0, 0, got);
        run_job(4'b0110, 2, 16'hfe80, 1'b1, 10, 0, got);

        run_job(4'b1111, 40, 16'h0000, 1'b0, 0, 5, got);
        run_job(4'b1111, 2, 16'h0042, 1'b1, 0, 0, got);
        check("after_reset_grant", FW'(got), FW'(4'b0001));

        for (int j = 0; j < 30; j++) begin
            if ($urandom_range(0, 3) == 0) idle_drop(NR'($urandom_range(1, 15)));
            lat = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 20) : $urandom_range(TO - 3, TO + 4);
            run_job(NR'($urandom_range(1, 15)), lat, DW'($urandom), 1'($urandom),
                    $urandom_range(0, 3), 0, got);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/svm_job_scheduler.md
SVM_JOB_SCHEDULER -- requirements
Module: svm_job_scheduler

Interface
REQ-001 The block SHALL have these parameters:
- NUM_REQ, default 4, number of requesters.
- DATA_WIDTH, default 16, Q8.8 word width.
- NUM_FEATURES, default 20, features per job.
- TIMEOUT_CYCLES, default 64, maximum number of WAIT cycles.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  permits new grants.
- req_valid  in  NUM_REQ  per-requester job request.
- req_features  in  NUM_REQ*NUM_FEATURES*DATA_WIDTH  flattened feature vectors; requester r at slice r.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- svm_input_valid  out  1  start pulse to the linear_svm core.
- svm_features_flat  out  NUM_FEATURES*DATA_WIDTH  latched features to the core.
- svm_output_valid  in  1  core result strobe.
- svm_decision  in  DATA_WIDTH  core decision value.
- svm_prediction  in  1  core prediction.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  clog2(NUM_REQ)  index of the requester that owns the job.
- rsp_decision  out  DATA_WIDTH  captured decision value.
- rsp_prediction  out  1  captured prediction.
- rsp_timeout  out  1  job ended by timeout.
- busy  out  1  state != IDLE.
- timeout_count  out  16  saturating timeout counter.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-004 IDLE: when enable=1 and any req_valid bit is set, req_ready SHALL combinationally assert one-hot for the round-robin winner.
- Search order starts at last_grant+1 and wraps modulo NUM_REQ.
REQ-005 On a req_valid&req_ready handshake, the block SHALL:
- latch the winner's feature slice into svm_features_flat;
- latch its index into rsp_id;
- move to ISSUE.
REQ-006 req_ready SHALL be all-zero in every state other than IDLE, and SHALL be all-zero in IDLE when enable=0.
REQ-007 ISSUE: svm_input_valid SHALL be 1 for exactly this one cycle, the WAIT timer SHALL clear to 0, and the next state SHALL be WAIT.
REQ-008 WAIT: the timer SHALL increment each cycle, and svm_output_valid=1 SHALL cause the block to:
- capture svm_decision and svm_prediction;
- set rsp_timeout=0;
- move to RESP.
REQ-009 WAIT: when the timer equals TIMEOUT_CYCLES-1 and svm_output_valid=0, the block SHALL:
- set rsp_decision=0, rsp_prediction=0 and rsp_timeout=1;
- increment timeout_count, saturating at 0xFFFF;
- move to RESP.
REQ-010 When svm_output_valid and timeout expiry occur in the same cycle, the valid result SHALL win and timeout_count SHALL be unchanged.
REQ-011 svm_output_valid SHALL be ignored in IDLE, ISSUE and RESP.
REQ-012 RESP: rsp_valid SHALL stay 1, with rsp_* stable, until rsp_ready=1.
- On that handshake, last_grant SHALL update to rsp_id and the next state SHALL be IDLE.
- rsp_valid SHALL be 0 in all other states.
REQ-013 Latency SHALL be fixed relative to the request handshake at edge T:
- svm_input_valid is high in cycle T+1;
- a core result at T+1+L gives rsp_valid from T+2+L;
- a new grant is possible no earlier than the cycle after the rsp handshake.
REQ-014 Deasserting enable mid-job SHALL NOT abort the job; it SHALL only block grants in IDLE.
REQ-015 A requester that drops req_valid before being granted SHALL simply not be selected, and no other state SHALL change.

Reset
REQ-016 Asserting rst_n=0 at any time, including mid-job, SHALL immediately do all of the following:
- force state to IDLE;
- clear req_ready, svm_input_valid, svm_features_flat, rsp_valid, rsp_id, rsp_decision, rsp_prediction, rsp_timeout, busy, timeout_count and the timer to 0;
- set last_grant to NUM_REQ-1, so requester 0 has first priority.
REQ-017 Any job in flight SHALL be discarded on reset, and a core result arriving after release SHALL be ignored.

Verification
REQ-018 Single job: req_valid=4'b0100 with features, core returns 0x0180 and prediction 1 at L=3 -> one svm_input_valid pulse; rsp_valid at handshake+5 with rsp_id=2, rsp_decision=0x0180, rsp_prediction=1, rsp_timeout=0.
REQ-019 Fairness: req_valid=4'b1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0; each req_ready is one-hot and lasts one cycle.
REQ-020 Timeout: core silent, TIMEOUT_CYCLES=64 -> rsp_timeout=1, rsp_decision=0 after 64 WAIT cycles; timeout_count=1.
REQ-021 Tie: svm_output_valid arrives on timer=63 -> rsp_timeout=0, decision captured, timeout_count unchanged.
REQ-022 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_* stable; req_ready stays 0 for all requesters.
REQ-023 Reset mid-WAIT: rst_n pulsed low -> all outputs 0 at once; a later svm_output_valid produces no rsp_valid; the next grant goes to requester 0.
